key_schedule_seq: RTL and testbench
===================================

// Module: key_schedule_seq
// PURPOSE
//  Sequential DES key schedule: accepts a 64-bit key, applies PC-1, then rotates the C/D halves once per round.
//  Emits the 16 round subkeys K1..K16 one per handshake through an instantiated pc2.
//  Sits between the key register and the round datapath (f-function XOR); decrypt mode emits K16..K1.
// PARAMETERS
//  ALLOW_RESTART  0  1: start while busy aborts the current run and reloads; 0: start is ignored while busy
// PORTS
//  clk           in   1   rising-edge clock, single clock domain
//  rst           in   1   synchronous active-high reset
//  start         in   1   load key_in and begin a schedule (accepted when ready=1, or any time if ALLOW_RESTART=1)
//  decrypt       in   1   sampled with start: 0 = K1..K16, 1 = K16..K1
//  key_in        in   64  DES key, bit 1 = key_in[63]; parity bits ignored by PC-1
//  ready         out  1   1 in IDLE
//  subkey_valid  out  1   current subkey is presented
//  subkey_ready  in   1   consumer accepts subkey this cycle
//  subkey        out  48  pc2(cd_reg), bit 1 = [47]
//  round_idx     out  4   DES round of presented subkey minus 1 (0..15), in DES numbering even when decrypting
//  last          out  1   subkey_valid and this is the 16th subkey of the run
//  cd_out        out  56  current C||D register (C = [55:28]), for debug/checking
// BEHAVIOUR
//  - Reset: state=IDLE, cd_reg=0, cnt=0, mode=0. Outputs: ready=1, subkey_valid=0, last=0, subkey=0, round_idx=0, cd_out=0.
//  - Shift table SH[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The sum is 28, so C16D16 == C0D0.
//  - Encrypt load, at the start edge: cd_reg <= rotl(PC1(key_in), SH[1]); cnt=0; state=RUN.
//  - Decrypt load, at the start edge: cd_reg <= PC1(key_in) (this is C16D16); cnt=0.
//  - C and D are rotated independently; rotl1(C) = {C[26:0],C[27]}, rotr1(C) = {C[0],C[27:1]}.
//  - Latency: first subkey_valid=1 on the cycle after start is accepted; there are no bubbles while subkey_ready=1.
//  - Transfer = subkey_valid & subkey_ready. On transfer with cnt<15: cnt++ and cd_reg advances.
//    - Encrypt: rotl by SH[cnt+2].
//    - Decrypt: rotr by SH[16-cnt] (right shifts 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
//  - Transfer with cnt==15: state <= IDLE (ready=1, valid=0 next cycle); cd_reg holds its value.
//  - round_idx = mode ? 15-cnt : cnt. last = subkey_valid & (cnt==15).
//  - Backpressure: subkey_ready=0 holds cd_reg, cnt, subkey and round_idx stable, with valid still asserted.
//  - start in IDLE on the same cycle as a final transfer is impossible (ready=0 during RUN). With ALLOW_RESTART=1, start in RUN wins over any transfer: reload as above.
//  - rst mid-run returns to the reset values at the next edge; no partial subkey is emitted.
//  - FSM: IDLE -(start)-> RUN; RUN -(transfer & cnt==15)-> IDLE; RUN -(start & ALLOW_RESTART)-> RUN(reload).
// STRUCTURE
//  - Package des_pkg holds: the PC1 index table (56 entries), the SH shift table, and the typedefs cd_t [55:0], subkey_t [47:0] and round_t [3:0].
//  - Instantiates the existing pc2 (key_in=cd_reg, key_out=subkey).
//  - PC-1 and the rotations are inline functions in des_pkg; there is no extra sub-module.
// TESTING
//  - Key 133457799BBCDFF1, encrypt, subkey_ready=1:
//    - cd_out after the load cycle is rotl1 of F0CCAAF556678F.
//    - K1=1B02EFFC7072, K2=79AED9DBC9E5, K16=CB3D8B0E17F5.
//    - 16 consecutive valids; last on K16.
//  - Same key, decrypt: first subkey=CB3D8B0E17F5 with round_idx=15; second is K15; final subkey=1B02EFFC7072 with round_idx=0 and last=1.
//  - Backpressure: drop subkey_ready for 3 cycles at round_idx=5 -> subkey/round_idx stable; the run still ends after exactly 16 transfers.
//  - start asserted during RUN, ALLOW_RESTART=0 -> ignored, sequence unchanged; ALLOW_RESTART=1 with a new key -> next cycle presents K1 of the new key.
//  - rst at round_idx=8 -> next cycle ready=1, valid=0, subkey=0; a subsequent start yields the correct K1.
//  - Random keys (100): each subkey matches a behavioural model (PC-1, shifts, pc2); cd_out after K16 equals PC1(key).

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule types, permutation tables and the rotation helpers.
package des_pkg;

    typedef logic [55:0] cd_t;
    typedef logic [47:0] subkey_t;
    typedef logic [3:0]  round_t;
    typedef logic [1:0]  shamt_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    // Entry i is the 1-based key bit (bit 1 = MSB) that lands in C||D bit i+1.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Left-shift count for rounds 1..16 (entry 0 is round 1); the total is 28.
    localparam shamt_t SH_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Parity bits (8, 16, ..., 64) never appear in the table, so they drop out here.
    function automatic cd_t pc1(input logic [63:0] key);
        cd_t r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = key[6'(64 - PC1_TBL[i])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] h, input shamt_t n);
        return (n == 2'd2) ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] h, input shamt_t n);
        return (n == 2'd2) ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

    // C and D rotate independently; they never exchange bits.
    function automatic cd_t rotl_cd(input cd_t cd, input shamt_t n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic cd_t rotr_cd(input cd_t cd, input shamt_t n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

    // Shift applied when leaving step cnt: encrypt moves to round cnt+2,
    // decrypt undoes the shift that produced round 16-cnt.
    function automatic shamt_t next_shift(input logic mode, input round_t cnt);
        return mode ? SH_TBL[4'd15 - cnt] : SH_TBL[cnt + 4'd1];
    endfunction

endpackage

// File: rtl/pc2.sv
// DES permuted choice 2: selects 48 of the 56 C||D bits to form a round subkey.
module pc2 import des_pkg::*; (
    input  cd_t     key_in,
    output subkey_t key_out
);

    // Entry i is the 1-based C||D bit (bit 1 = MSB) that lands in subkey bit i+1.
    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Pure bit selection, no logic gates.
    always_comb begin
        key_out = '0;
        for (int i = 0; i < 48; i++) begin
            key_out[6'(47 - i)] = key_in[6'(56 - PC2_TBL[i])];
        end
    end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential DES key schedule: loads a key, then hands out one round subkey
// per valid/ready transfer, K1..K16 for encrypt or K16..K1 for decrypt.
//
//  state | meaning
//  IDLE  | no schedule in progress, ready=1, waiting for start
//  RUN   | presenting the subkey for step cnt (0..15), advancing on each transfer
module key_schedule_seq import des_pkg::*; #(
    parameter bit ALLOW_RESTART = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic        ready,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output subkey_t     subkey,
    output round_t      round_idx,
    output logic        last,
    output cd_t         cd_out
);

    ks_state_t state, state_nxt;
    cd_t       cd_reg, cd_nxt;
    round_t    cnt, cnt_nxt;
    logic      mode, mode_nxt;
    logic      accept;
    logic      transfer;
    cd_t       cd_loaded;

    // State and schedule registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cd_reg <= '0;
            cnt    <= '0;
            mode   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cd_reg <= cd_nxt;
            cnt    <= cnt_nxt;
            mode   <= mode_nxt;
        end
    end

    // Next-state and outputs; a restart takes priority over a pending transfer.
    always_comb begin
        state_nxt    = state;
        cd_nxt       = cd_reg;
        cnt_nxt      = cnt;
        mode_nxt     = mode;
        ready        = (state == IDLE);
        subkey_valid = (state == RUN);
        transfer     = subkey_valid && subkey_ready;
        last         = subkey_valid && (cnt == 4'd15);
        round_idx    = mode ? (4'd15 - cnt) : cnt;
        cd_out       = cd_reg;
        accept       = start && ((state == IDLE) || ALLOW_RESTART);
        // C16D16 equals C0D0, so decrypt starts directly from the PC-1 result.
        cd_loaded    = decrypt ? pc1(key_in) : rotl_cd(pc1(key_in), SH_TBL[0]);

        if (accept) begin
            state_nxt = RUN;
            cd_nxt    = cd_loaded;
            cnt_nxt   = '0;
            mode_nxt  = decrypt;
        end else if (transfer) begin
            if (cnt == 4'd15) begin
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + 4'd1;
                cd_nxt  = mode ? rotr_cd(cd_reg, next_shift(mode, cnt))
                               : rotl_cd(cd_reg, next_shift(mode, cnt));
            end
        end
    end

    pc2 u_pc2 (
        .key_in  (cd_reg),
        .key_out (subkey)
    );

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed and random-key checks of key_schedule_seq against an independent
// bit-serial model of PC-1, the shift schedule and PC-2.
module tb_key_schedule_seq;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic        subkey_ready;

    logic        rdy0, vld0, last0, rdy1, vld1, last1;
    logic [47:0] sk0, sk1;
    logic [3:0]  ri0, ri1;
    logic [55:0] cd0, cd1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [47:0] exp_ks [16];
    logic [47:0] ks_a   [16];
    logic [47:0] obs    [16];
    logic [55:0] first_cd;

    always #5 clk = ~clk;

    key_schedule_seq #(.ALLOW_RESTART(1'b0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .ready        (rdy0),
        .subkey_valid (vld0),
        .subkey_ready (subkey_ready),
        .subkey       (sk0),
        .round_idx    (ri0),
        .last         (last0),
        .cd_out       (cd0)
    );

    key_schedule_seq #(.ALLOW_RESTART(1'b1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .ready        (rdy1),
        .subkey_valid (vld1),
        .subkey_ready (subkey_ready),
        .subkey       (sk1),
        .round_idx    (ri1),
        .last         (last1),
        .cd_out       (cd1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] m_pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [63:0] t;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            t = k >> (64 - M_PC1[i]);
            r = {r[54:0], t[0]};
        end
        return r;
    endfunction

    function automatic logic [47:0] m_pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [55:0] t;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            t = cd >> (56 - M_PC2[i]);
            r = {r[46:0], t[0]};
        end
        return r;
    endfunction

    function automatic logic [55:0] m_rotl1(input logic [55:0] cd);
        return {cd[54:28], cd[55], cd[26:0], cd[27]};
    endfunction

    // Fills exp_ks[r] with K(r+1) by single-bit rotations of C and D.
    task automatic m_sched(input logic [63:0] k);
        logic [55:0] cd;
        cd = m_pc1(k);
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < M_SH[r]; s++) cd = m_rotl1(cd);
            exp_ks[r] = m_pc2(cd);
        end
    endtask

    // One full run on dut0; optional 3-cycle stall while round_idx == stall_at.
    task automatic run_sched(input logic [63:0] k, input logic dec, input int stall_at);
        int n;
        int idx;
        bit stalled;
        m_sched(k);
        subkey_ready = 1'b1;
        key_in  = k;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        decrypt  = 1'b0;
        first_cd = cd0;
        n = 0;
        stalled = 1'b0;
        for (int g = 0; g < 80 && !rdy0; g++) begin
            if (n > 15) break;
            idx = dec ? 15 - n : n;
            chk("valid", 64'(vld0), 64'(1));
            chk("round_idx", 64'(ri0), 64'(idx));
            chk("subkey", 64'(sk0), 64'(exp_ks[idx]));
            chk("last", 64'(last0), 64'(n == 15));
            obs[n] = sk0;
            if (idx == stall_at && !stalled) begin
                stalled = 1'b1;
                subkey_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("bp_valid", 64'(vld0), 64'(1));
                    chk("bp_round_idx", 64'(ri0), 64'(idx));
                    chk("bp_subkey", 64'(sk0), 64'(exp_ks[idx]));
                end
                subkey_ready = 1'b1;
            end
            tick();
            n++;
        end
        chk("transfers", 64'(n), 64'(16));
        chk("ready_at_end", 64'(rdy0), 64'(1));
        chk("valid_at_end", 64'(vld0), 64'(0));
    endtask

    initial begin
        int n0;
        int n1;
        logic [63:0] rk;
        logic        rd;

        rst = 1'b1;
        start = 1'b0;
        decrypt = 1'b0;
        key_in = '0;
        subkey_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_ready", 64'(rdy0), 64'(1));
        chk("rst_valid", 64'(vld0), 64'(0));
        chk("rst_last", 64'(last0), 64'(0));
        chk("rst_subkey", 64'(sk0), 64'(0));
        chk("rst_round_idx", 64'(ri0), 64'(0));
        chk("rst_cd_out", 64'(cd0), 64'(0));

        // Reference key, encrypt.
        run_sched(KEY_A, 1'b0, -1);
        chk("enc_cd_load", 64'(first_cd), 64'(56'hE19955FAACCF1E));
        chk("enc_k1", 64'(obs[0]), 64'(48'h1B02EFFC7072));
        chk("enc_k2", 64'(obs[1]), 64'(48'h79AED9DBC9E5));
        chk("enc_k16", 64'(obs[15]), 64'(48'hCB3D8B0E17F5));
        chk("enc_cd_end", 64'(cd0), 64'(56'hF0CCAAF556678F));

        // Reference key, decrypt.
        run_sched(KEY_A, 1'b1, -1);
        chk("dec_cd_load", 64'(first_cd), 64'(56'hF0CCAAF556678F));
        chk("dec_first_k16", 64'(obs[0]), 64'(48'hCB3D8B0E17F5));
        chk("dec_second_k15", 64'(obs[1]), 64'(48'hBF918D3D3F0A));
        chk("dec_final_k1", 64'(obs[15]), 64'(48'h1B02EFFC7072));

        // Backpressure at round_idx 5.
        run_sched(KEY_A, 1'b0, 5);

        // start during RUN: ignored by dut0, reloads dut1.
        m_sched(KEY_A);
        for (int i = 0; i < 16; i++) ks_a[i] = exp_ks[i];
        m_sched(KEY_B);
        key_in = KEY_A;
        decrypt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        key_in = KEY_B;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("norestart_round_idx", 64'(ri0), 64'(5));
        chk("norestart_subkey", 64'(sk0), 64'(ks_a[5]));
        chk("restart_round_idx", 64'(ri1), 64'(0));
        chk("restart_subkey", 64'(sk1), 64'(exp_ks[0]));
        chk("restart_cd_out", 64'(cd1), 64'(m_rotl1(m_pc1(KEY_B))));
        n0 = 5;
        n1 = 0;
        for (int g = 0; g < 60 && !(rdy0 && rdy1); g++) begin
            if (vld0) n0++;
            if (vld1) n1++;
            tick();
        end
        chk("norestart_transfers", 64'(n0), 64'(16));
        chk("restart_transfers", 64'(n1), 64'(16));

        // Reset in the middle of a run.
        key_in = KEY_A;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("mid_round_idx", 64'(ri0), 64'(8));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", 64'(rdy0), 64'(1));
        chk("midrst_valid", 64'(vld0), 64'(0));
        chk("midrst_subkey", 64'(sk0), 64'(0));
        chk("midrst_last", 64'(last0), 64'(0));
        run_sched(KEY_A, 1'b0, -1);
        chk("midrst_k1", 64'(obs[0]), 64'(48'h1B02EFFC7072));

        // Random keys, alternating direction.
        for (int i = 0; i < 100; i++) begin
            rk = {$urandom, $urandom};
            rd = (i % 2) == 1;
            run_sched(rk, rd, -1);
            if (!rd) chk("rand_cd_end", 64'(cd0), 64'(m_pc1(rk)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
